// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus target: CA field positions, register map and FSM states.
package hyperbus_pkg;

  localparam int unsigned CA_RW = 47;
  localparam int unsigned CA_AS = 46;
  localparam int unsigned CA_BT = 45;

  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_ID1 = 32'h0000_0001;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;
  localparam logic [31:0] REG_CR1 = 32'h0000_0801;
  localparam logic [15:0] CR1_VALUE = 16'h0002;

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA} state_t;

endpackage

// File: rtl/hyperbus_edge_det.sv
// Two-flop synchronizer for hbus_clk with rise/fall pulses, flagged one clk after the edge.
module hyperbus_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic hbus_clk,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], hbus_clk};
  end

  assign rise_c = sync_q[0] & ~sync_q[1];
  assign fall_c = ~sync_q[0] & sync_q[1];

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus x8 responder emulating a HyperRAM on top of a synchronous 16-bit word memory port.
module hyperbus_target
  import hyperbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 22,
  parameter int unsigned LATENCY       = 6,
  parameter int unsigned FIXED_LATENCY = 1,
  parameter int unsigned WRAP_WORDS    = 16,
  parameter logic [15:0] ID0           = 16'h0C81,
  parameter logic [15:0] ID1           = 16'h0001,
  parameter logic [15:0] CR0_RESET     = 16'h8F1F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hbus_clk,
  input  logic                  hbus_csn,
  input  logic                  hbus_rstn,
  input  logic [7:0]            dq_i,
  output logic [7:0]            dq_o,
  output logic                  dq_oe,
  input  logic                  rwds_i,
  output logic                  rwds_o,
  output logic                  rwds_oe,
  input  logic                  collision_i,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic                  mem_re,
  input  logic [15:0]           mem_rdat,
  output logic                  mem_we,
  output logic [1:0]            mem_be,
  output logic [15:0]           mem_wdat
);

  localparam int unsigned WRAP_BITS = $clog2(WRAP_WORDS);
  localparam int unsigned LAT_W     = 8;
  localparam logic [LAT_W-1:0] LAT_SINGLE = LAT_W'(LATENCY);
  localparam logic [LAT_W-1:0] LAT_DOUBLE = LAT_W'(2 * LATENCY);

  state_t                  state_q, state_d;
  logic [39:0]             ca_q;
  logic [2:0]              ca_cnt_q;
  logic [LAT_W-1:0]        lat_cnt_q;
  logic                    rd_q, reg_q, lin_q, dbl_q, done_q, rd_pend_q, be_hi_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              hi_q;
  logic [15:0]             rd_word_q, cr0_q;

  logic                    rise_c, fall_c;
  logic [47:0]             ca_c;
  logic [31:0]             ca_word_c;
  logic [ADDR_WIDTH-1:0]   start_c;
  logic [LAT_W-1:0]        lat_tgt_c;
  logic                    ca_last_c, lat_last_c, data_rise_c, data_fall_c, reg_wr_c;
  logic                    unused_ca;

  hyperbus_edge_det u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .hbus_clk (hbus_clk),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic lin);
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + ADDR_WIDTH'(1);
    if (lin) return inc;
    return {a[ADDR_WIDTH-1:WRAP_BITS], inc[WRAP_BITS-1:0]};
  endfunction

  function automatic logic [15:0] reg_read(input logic [31:0] wa, input logic [15:0] cr0);
    case (wa)
      REG_ID0: return ID0;
      REG_ID1: return ID1;
      REG_CR0: return cr0;
      REG_CR1: return CR1_VALUE;
      default: return 16'h0000;
    endcase
  endfunction

  // The sixth CA byte is decoded straight off the bus, before it lands in ca_q.
  assign ca_c        = {ca_q, dq_i};
  assign ca_word_c   = {ca_c[44:16], ca_c[2:0]};
  assign start_c     = ADDR_WIDTH'(ca_word_c);
  assign unused_ca   = ^ca_c[15:3];
  assign reg_wr_c    = !ca_c[CA_RW] && ca_c[CA_AS];
  assign lat_tgt_c   = dbl_q ? LAT_DOUBLE : LAT_SINGLE;
  assign ca_last_c   = (state_q == CA) && fall_c && (ca_cnt_q == 3'd5);
  assign lat_last_c  = (state_q == LAT) && rise_c && ((lat_cnt_q + LAT_W'(1)) == lat_tgt_c);
  assign data_rise_c = rise_c && !done_q && ((state_q inside {WDATA, RDATA}) || lat_last_c);
  assign data_fall_c = fall_c && !done_q && (state_q inside {WDATA, RDATA});

  always_ff @(posedge clk) begin
    if (!rst || !hbus_rstn) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!hbus_csn) state_d = CA;
      CA:      if (ca_last_c) state_d = reg_wr_c ? WDATA : LAT;
      LAT:     if (lat_last_c) state_d = rd_q ? RDATA : WDATA;
      default: ;
    endcase
    if (hbus_csn) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst || !hbus_rstn) begin
      dq_o      <= '0;
      dq_oe     <= 1'b0;
      rwds_o    <= 1'b0;
      rwds_oe   <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_adr   <= '0;
      mem_wdat  <= '0;
      ca_q      <= '0;
      ca_cnt_q  <= '0;
      lat_cnt_q <= '0;
      rd_q      <= 1'b0;
      reg_q     <= 1'b0;
      lin_q     <= 1'b0;
      dbl_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      be_hi_q   <= 1'b0;
      addr_q    <= '0;
      hi_q      <= '0;
      rd_word_q <= '0;
      cr0_q     <= CR0_RESET;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      rd_pend_q <= mem_re;
      if (rd_pend_q) rd_word_q <= mem_rdat;

      if (hbus_csn || state_q == IDLE) begin
        // Bus released: drop drivers and any partially assembled word.
        dq_o      <= '0;
        dq_oe     <= 1'b0;
        rwds_o    <= 1'b0;
        rwds_oe   <= 1'b0;
        ca_cnt_q  <= '0;
        lat_cnt_q <= '0;
        done_q    <= 1'b0;
        be_hi_q   <= 1'b0;
        hi_q      <= '0;
        dbl_q     <= (FIXED_LATENCY != 0);
      end else begin
        case (state_q)
          CA: begin
            dq_oe   <= 1'b0;
            rwds_oe <= 1'b1;
            rwds_o  <= dbl_q | collision_i;
            dbl_q   <= dbl_q | collision_i;
            if (rise_c || fall_c) begin
              ca_q     <= ca_c[39:0];
              ca_cnt_q <= ca_cnt_q + 3'd1;
            end
            if (ca_last_c) begin
              rd_q   <= ca_c[CA_RW];
              reg_q  <= ca_c[CA_AS];
              lin_q  <= ca_c[CA_BT];
              addr_q <= start_c;
              if (reg_wr_c) rwds_oe <= 1'b0;
              if (ca_c[CA_RW] && ca_c[CA_AS]) rd_word_q <= reg_read(ca_word_c, cr0_q);
              if (ca_c[CA_RW] && !ca_c[CA_AS]) begin
                mem_re  <= 1'b1;
                mem_adr <= start_c;
                addr_q  <= next_addr(start_c, ca_c[CA_BT]);
              end
            end
          end
          LAT: begin
            rwds_oe <= rd_q;
            rwds_o  <= 1'b0;
            if (rise_c) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
          RDATA: begin
            dq_oe   <= 1'b1;
            rwds_oe <= 1'b1;
          end
          WDATA:   rwds_oe <= 1'b0;
          default: ;
        endcase

        if (data_rise_c) begin
          if (rd_q) begin
            dq_oe   <= 1'b1;
            rwds_oe <= 1'b1;
            dq_o    <= rd_word_q[15:8];
            rwds_o  <= 1'b1;
          end else begin
            hi_q    <= dq_i;
            be_hi_q <= ~rwds_i;
          end
        end

        if (data_fall_c) begin
          if (rd_q) begin
            dq_o   <= rd_word_q[7:0];
            rwds_o <= 1'b0;
            if (!reg_q) begin
              mem_re  <= 1'b1;
              mem_adr <= addr_q;
              addr_q  <= next_addr(addr_q, lin_q);
            end
          end else if (reg_q) begin
            // Register writes take a single word; later edges are ignored until deselect.
            if (addr_q == ADDR_WIDTH'(REG_CR0)) cr0_q <= {hi_q, dq_i};
            done_q <= 1'b1;
          end else begin
            mem_we   <= be_hi_q | ~rwds_i;
            mem_be   <= {be_hi_q, ~rwds_i};
            mem_wdat <= {hi_q, dq_i};
            mem_adr  <= addr_q;
            addr_q   <= next_addr(addr_q, lin_q);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: memory/register reads and writes, masking, wrap, abort and reset.
module tb_hyperbus_target;
  import hyperbus_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, hbus_clk = 1'b0, hbus_csn = 1'b1, hbus_rstn = 1'b1;
  logic        rwds_i = 1'b0, collision_i = 1'b0;
  logic [7:0]  dq_i = 8'h00;
  logic [7:0]  dq_o;
  logic        dq_oe, rwds_o, rwds_oe, mem_re, mem_we;
  logic [21:0] mem_adr;
  logic [15:0] mem_rdat = 16'h0000;
  logic [15:0] mem_wdat;
  logic [1:0]  mem_be;

  localparam int LAT_CYC = 11;  // rises before the data rise: 2*LATENCY-1

  hyperbus_target #(
    .ADDR_WIDTH(22), .LATENCY(6), .FIXED_LATENCY(1), .WRAP_WORDS(16),
    .ID0(16'h0C81), .ID1(16'h0001), .CR0_RESET(16'h8F1F)
  ) dut (
    .clk(clk), .rst(rst), .hbus_clk(hbus_clk), .hbus_csn(hbus_csn), .hbus_rstn(hbus_rstn),
    .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .rwds_i(rwds_i), .rwds_o(rwds_o),
    .rwds_oe(rwds_oe), .collision_i(collision_i), .mem_adr(mem_adr), .mem_re(mem_re),
    .mem_rdat(mem_rdat), .mem_we(mem_we), .mem_be(mem_be), .mem_wdat(mem_wdat)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  logic [21:0] we_adr [$];
  logic [1:0]  we_be  [$];
  logic [15:0] we_dat [$];
  logic [21:0] re_adr [$];

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdat <= mem[mem_adr[7:0]];
      re_adr.push_back(mem_adr);
    end
    if (mem_we) begin
      we_adr.push_back(mem_adr);
      we_be.push_back(mem_be);
      we_dat.push_back(mem_wdat);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic lin,
                                          input logic [31:0] wa);
    return {rd, rg, lin, wa[31:3], 13'h0000, wa[2:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One hbus_clk half period: data set up before the edge, held well past the sampling point.
  task automatic half(input logic [7:0] d, input logic m);
    dq_i   = d;
    rwds_i = m;
    tick(2);
    hbus_clk = ~hbus_clk;
    tick(2);
  endtask

  task automatic start_ca(input logic [47:0] ca);
    hbus_csn = 1'b0;
    tick(4);
    for (int i = 5; i >= 0; i--) half(ca[i*8 +: 8], 1'b0);
  endtask

  task automatic lat_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      half(8'h00, 1'b0);
      half(8'h00, 1'b0);
    end
  endtask

  task automatic end_txn();
    tick(2);
    hbus_csn = 1'b1;
    hbus_clk = 1'b0;
    tick(6);
  endtask

  task automatic read_word(input string tag, input logic [15:0] want);
    half(8'h00, 1'b0);
    check({tag, ".hi"}, 32'(dq_o), 32'(want[15:8]));
    check({tag, ".rwds_hi"}, 32'(rwds_o), 32'd1);
    half(8'h00, 1'b0);
    check({tag, ".lo"}, 32'(dq_o), 32'(want[7:0]));
    check({tag, ".rwds_lo"}, 32'(rwds_o), 32'd0);
  endtask

  initial begin
    int base, rbase;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset state
    tick(4);
    check("rst.dq_oe", 32'(dq_oe), 32'd0);
    check("rst.rwds_oe", 32'(rwds_oe), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_re", 32'(mem_re), 32'd0);
    check("rst.mem_adr", 32'(mem_adr), 32'd0);
    check("rst.state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b1;
    tick(4);

    // 1: linear write of two words at 0x10
    base = we_adr.size();
    start_ca(make_ca(1'b0, 1'b0, 1'b1, 32'h10));
    lat_cycles(LAT_CYC);
    half(8'hA5, 1'b0); half(8'h5A, 1'b0);
    half(8'h12, 1'b0); half(8'h34, 1'b0);
    end_txn();
    check("t1.count", 32'(we_adr.size() - base), 32'd2);
    if (we_adr.size() - base == 2) begin
      check("t1.adr0", 32'(we_adr[base]), 32'h10);
      check("t1.be0", 32'(we_be[base]), 32'h3);
      check("t1.dat0", 32'(we_dat[base]), 32'hA55A);
      check("t1.adr1", 32'(we_adr[base+1]), 32'h11);
      check("t1.be1", 32'(we_be[base+1]), 32'h3);
      check("t1.dat1", 32'(we_dat[base+1]), 32'h1234);
    end

    // 2: upper byte masked
    base = we_adr.size();
    start_ca(make_ca(1'b0, 1'b0, 1'b1, 32'h20));
    lat_cycles(LAT_CYC);
    half(8'hBE, 1'b1); half(8'hEF, 1'b0);
    end_txn();
    check("t2.count", 32'(we_adr.size() - base), 32'd1);
    if (we_adr.size() - base == 1) begin
      check("t2.be", 32'(we_be[base]), 32'h1);
      check("t2.lo", 32'(we_dat[base][7:0]), 32'hEF);
      check("t2.adr", 32'(we_adr[base]), 32'h20);
    end

    // 3: linear read of three words from 0x10, first data on rise 12
    mem[8'h10] = 16'h1111; mem[8'h11] = 16'h2222; mem[8'h12] = 16'h3333;
    start_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10));
    lat_cycles(LAT_CYC);
    check("t3.oe_before", 32'(dq_oe), 32'd0);
    read_word("t3.w0", 16'h1111);
    check("t3.oe_data", 32'(dq_oe), 32'd1);
    read_word("t3.w1", 16'h2222);
    read_word("t3.w2", 16'h3333);
    end_txn();

    // 4: wrapped read from 0x0E crosses the 16-word group boundary
    mem[8'h0E] = 16'hAE01; mem[8'h0F] = 16'hBF02; mem[8'h00] = 16'hC003; mem[8'h01] = 16'hD104;
    rbase = re_adr.size();
    start_ca(make_ca(1'b1, 1'b0, 1'b0, 32'h0E));
    lat_cycles(LAT_CYC);
    read_word("t4.w0", 16'hAE01);
    read_word("t4.w1", 16'hBF02);
    read_word("t4.w2", 16'hC003);
    read_word("t4.w3", 16'hD104);
    end_txn();
    check("t4.re_count_ge4", 32'(re_adr.size() - rbase >= 4), 32'd1);
    if (re_adr.size() - rbase >= 4) begin
      check("t4.adr0", 32'(re_adr[rbase]), 32'h0E);
      check("t4.adr1", 32'(re_adr[rbase+1]), 32'h0F);
      check("t4.adr2", 32'(re_adr[rbase+2]), 32'h00);
      check("t4.adr3", 32'(re_adr[rbase+3]), 32'h01);
    end

    // 5: register write CR0, read back CR0 and ID0, no memory traffic
    base  = we_adr.size();
    rbase = re_adr.size();
    start_ca(make_ca(1'b0, 1'b1, 1'b1, 32'h800));
    half(8'h8F, 1'b0); half(8'h17, 1'b0);
    half(8'hFF, 1'b0); half(8'hFF, 1'b0);
    end_txn();
    start_ca(make_ca(1'b1, 1'b1, 1'b1, 32'h800));
    lat_cycles(LAT_CYC);
    read_word("t5.cr0", 16'h8F17);
    end_txn();
    start_ca(make_ca(1'b1, 1'b1, 1'b1, 32'h0));
    lat_cycles(LAT_CYC);
    read_word("t5.id0", 16'h0C81);
    end_txn();
    check("t5.no_we", 32'(we_adr.size() - base), 32'd0);
    check("t5.no_re", 32'(re_adr.size() - rbase), 32'd0);

    // 6a: deselect after only the upper write byte discards the word
    base = we_adr.size();
    start_ca(make_ca(1'b0, 1'b0, 1'b1, 32'h30));
    lat_cycles(LAT_CYC);
    half(8'h77, 1'b0);
    hbus_csn = 1'b1;
    tick(3);
    hbus_clk = 1'b0;
    tick(6);
    check("t6.no_we", 32'(we_adr.size() - base), 32'd0);
    check("t6.state_abort", 32'(dut.state_q), 32'(IDLE));

    // 6b: synchronous reset mid-read
    start_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10));
    lat_cycles(LAT_CYC);
    half(8'h00, 1'b0);
    check("t6.oe_mid", 32'(dq_oe), 32'd1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("t6.dq_oe", 32'(dq_oe), 32'd0);
    check("t6.rwds_oe", 32'(rwds_oe), 32'd0);
    check("t6.state_rst", 32'(dut.state_q), 32'(IDLE));
    hbus_csn = 1'b1;
    hbus_clk = 1'b0;
    tick(6);
    start_ca(make_ca(1'b1, 1'b1, 1'b1, 32'h800));
    lat_cycles(LAT_CYC);
    read_word("t6.cr0", 16'h8F1F);
    end_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
